move_checker: RTL and testbench
===============================

# move_checker

Parametrised, sequential successor to the down-only collision check. It answers "can the active piece move down, left, right or rotate clockwise?" for a configurable board size. Rather than wiring the whole board combinationally, it walks the four cells of the target piece position through a single synchronous board read port. It sits between the game-control FSM (Start/Done handshake) and the board RAM.

## Interface
- ROWS, 20, board rows; row 0 is the top.
- COLS, 16, board columns.
- CW, 3, bits per board cell; 0 means empty.
- XW = $clog2(COLS), YW = $clog2(ROWS): localparams, not overridable.
- Clock  in  1  single clock; all logic on posedge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  request; sampled only in IDLE.
- Direction  in  2  00 down, 01 left, 10 right, 11 rotate clockwise.
- currentBlock  in  4  piece code 0..14; 15 is illegal.
- XPOS  in  XW  column of the piece's 4x4 box origin.
- YPOS  in  YW  row of the piece's 4x4 box origin.
- rdEn  out  1  board read strobe.
- rdRow  out  YW  board read row.
- rdCol  out  XW  board read column.
- rdData  in  CW  board cell; valid the cycle after rdEn.
- Busy  out  1  high whenever state is not IDLE.
- Done  out  1  one-cycle result strobe.
- canMove  out  1  result; held until the next Done.

## Operation
- Piece cells are given as (row, col) inside the 4x4 box, in check order 0..3:
  - 0 I1: (3,0)(3,1)(3,2)(3,3)
  - 1 I2: (0,1)(1,1)(2,1)(3,1)
  - 2 O: (2,1)(2,2)(3,1)(3,2)
  - 3 S1: (2,1)(2,2)(3,0)(3,1)
  - 4 S2: (1,0)(2,0)(2,1)(3,1)
  - 5 J1: (2,0)(3,0)(3,1)(3,2)
  - 6 J2: (1,1)(1,2)(2,1)(3,1)
  - 7 J3: (2,0)(2,1)(2,2)(3,2)
  - 8 J4: (1,2)(2,2)(3,1)(3,2)
  - 9 T1: (2,1)(3,0)(3,1)(3,2)
  - 10 T2: (1,1)(2,1)(2,2)(3,1)
  - 11 T3: (2,0)(2,1)(2,2)(3,1)
  - 12 T4: (1,2)(2,1)(2,2)(3,2)
  - 13 Z1: (2,0)(2,1)(3,1)(3,2)
  - 14 Z2: (1,2)(2,1)(2,2)(3,1)
- Target offsets (dy, dx): down (+1, 0); left (0, -1); right (0, +1); rotate (0, 0) using the next piece code.
- Rotation map: I1↔I2, O→O, S1↔S2, J1→J2→J3→J4→J1, T1→T2→T3→T4→T1, Z1↔Z2.
- Target cell coordinates: row = YPOS + dy + r and col = XPOS + dx + c, computed signed, one bit wider than YW/XW.
- A cell is out of bounds if col < 0, col ≥ COLS, or row ≥ ROWS. An out-of-bounds cell blocks the move and issues no read.
- A cell whose rdData is nonzero blocks the move.
- currentBlock = 15 blocks the move immediately, with no reads.
- FSM:
  - IDLE: Start latches Direction, currentBlock, XPOS and YPOS; idx ← 0; go to CELL.
  - CELL: if the illegal code or cell idx is out of bounds, set blocked and go to DONE. Otherwise rdEn = 1 with rdRow/rdCol = target; go to WAIT.
  - WAIT: if rdData ≠ 0, set blocked and go to DONE. Else if idx = 3, go to DONE. Else idx++ and go to CELL.
  - DONE: Done = 1; canMove = !blocked; go to IDLE.
- Checking stops at the first blocking cell; later cells are not read.
- Start is ignored while Busy. Inputs may change after the Start edge without affecting the check.

## Timing
- Reset values: state IDLE; Busy, Done, canMove, rdEn = 0; rdRow, rdCol = 0.
- Reset mid-check aborts the check: no Done is produced and canMove returns to 0.
- With Start sampled at edge 0:
  - All four cells free: DONE is entered at edge 8, so Done is high in cycle 8 and the block is back in IDLE at edge 9.
  - Blocked by rdData at cell k: DONE at edge 2k+2.
  - Out of bounds (or illegal code) at cell k: DONE at edge 2k+1.
- rdEn is high only in CELL, for exactly one cycle per read.
- rdData is sampled in WAIT, i.e. one cycle after rdEn.
- Busy is high from edge 0 through the DONE cycle inclusive.
- The earliest accepted next Start is the edge that leaves DONE plus one (the block must be in IDLE).

## Test plan
- Empty board; I1, X=0, Y=0, down → four reads of (4,0..3); Done at edge 8; canMove = 1.
- I1, X=0, Y=16, down → cell 0 at row 20 is out of bounds; rdEn never asserted; Done at edge 1; canMove = 0.
- board[13][6] = 3'b101; T1, X=5, Y=10, down → read (13,6) only; Done at edge 2; canMove = 0.
- J1, X=0, left → col -1 out of bounds, Done at edge 1, canMove = 0.
- I1, X=12, right → reads cols 13, 14, 15 as free; col 16 is out of bounds; Done at edge 7; canMove = 0.
- board[7][5] = 1; T1, X=3, Y=5, rotate → T2 cells (6,4), (7,4), (7,5) read; Done at edge 6; canMove = 0.
- currentBlock = 15 → Done at edge 1, canMove = 0.
- Start pulsed at edge 2 while Busy → ignored; only one Done.
- Reset at edge 3 mid-check → no Done; all outputs 0 from edge 3.

Source files
------------

// File: rtl/move_checker_if.sv
// move_checker_if
//   Bundles the two sides of the move checker:
//   - request side  : Start, Direction, currentBlock, XPOS, YPOS in;
//                     Busy, Done, canMove out
//   - board read    : rdEn, rdRow, rdCol out; rdData in (one cycle after rdEn)
//   Modport slave is the checker's view; modport master is the view of the
//   game controller / board RAM that surrounds it.
interface move_checker_if #(
  parameter int ROWS = 20,
  parameter int COLS = 16,
  parameter int CW   = 3
);
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);

  logic          Start;
  logic [1:0]    Direction;
  logic [3:0]    currentBlock;
  logic [XW-1:0] XPOS;
  logic [YW-1:0] YPOS;
  logic          rdEn;
  logic [YW-1:0] rdRow;
  logic [XW-1:0] rdCol;
  logic [CW-1:0] rdData;
  logic          Busy;
  logic          Done;
  logic          canMove;

  modport master (
    output Start, Direction, currentBlock, XPOS, YPOS, rdData,
    input  rdEn, rdRow, rdCol, Busy, Done, canMove
  );

  modport slave (
    input  Start, Direction, currentBlock, XPOS, YPOS, rdData,
    output rdEn, rdRow, rdCol, Busy, Done, canMove
  );
endinterface

// File: rtl/move_checker.sv
// move_checker
//   Answers whether the active piece can move down, left, right or rotate
//   clockwise by walking the four cells of the target position through one
//   synchronous board read port.
//   Ports:
//     Clock  - single clock, posedge
//     Reset  - synchronous, active-high
//     bus    - move_checker_if.slave (request handshake + board read port)
module move_checker #(
  parameter int ROWS = 20,
  parameter int COLS = 16,
  parameter int CW   = 3
) (
  input  logic          Clock,
  input  logic          Reset,
  move_checker_if.slave bus
);
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);

  typedef enum logic [1:0] {S_IDLE, S_CELL, S_WAIT, S_DONE} state_t;

  state_t        r_state, w_state_next;
  logic [1:0]    r_dir;
  logic [3:0]    r_blk;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [1:0]    r_idx;
  logic          r_canMove;

  logic [3:0]        w_code;
  logic [15:0]       w_cells;
  logic [1:0]        w_r, w_c;
  logic              w_dy;
  logic signed [XW:0] w_dx;
  logic signed [YW:0] w_row;
  logic signed [XW:0] w_col;
  logic              w_illegal, w_oob, w_block, w_rdEn;

  // Four (row,col) pairs packed {r0,c0,r1,c1,r2,c2,r3,c3}, 2 bits each,
  // listed in check order.
  function automatic logic [15:0] piece_cells(input logic [3:0] code);
    case (code)
      4'd0:    return 16'hCDEF; // I1
      4'd1:    return 16'h159D; // I2
      4'd2:    return 16'h9ADE; // O
      4'd3:    return 16'h9ACD; // S1
      4'd4:    return 16'h489D; // S2
      4'd5:    return 16'h8CDE; // J1
      4'd6:    return 16'h569D; // J2
      4'd7:    return 16'h89AE; // J3
      4'd8:    return 16'h6ADE; // J4
      4'd9:    return 16'h9CDE; // T1
      4'd10:   return 16'h59AD; // T2
      4'd11:   return 16'h89AD; // T3
      4'd12:   return 16'h69AE; // T4
      4'd13:   return 16'h89DE; // Z1
      4'd14:   return 16'h69AD; // Z2
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [3:0] rotate_cw(input logic [3:0] code);
    case (code)
      4'd0:    return 4'd1;
      4'd1:    return 4'd0;
      4'd3:    return 4'd4;
      4'd4:    return 4'd3;
      4'd8:    return 4'd5;
      4'd12:   return 4'd9;
      4'd13:   return 4'd14;
      4'd14:   return 4'd13;
      4'd5, 4'd6, 4'd7,
      4'd9, 4'd10, 4'd11: return code + 4'd1;
      default: return code; // O and the illegal code map to themselves
    endcase
  endfunction

  // Target cell for the current index
  always_comb begin
    w_code  = (r_dir == 2'b11) ? rotate_cw(r_blk) : r_blk;
    w_cells = piece_cells(w_code);
    case (r_idx)
      2'd0:    {w_r, w_c} = w_cells[15:12];
      2'd1:    {w_r, w_c} = w_cells[11:8];
      2'd2:    {w_r, w_c} = w_cells[7:4];
      default: {w_r, w_c} = w_cells[3:0];
    endcase
    w_dy = (r_dir == 2'b00);
    case (r_dir)
      2'b01:   w_dx = '1;                     // -1
      2'b10:   w_dx = {{XW{1'b0}}, 1'b1};     // +1
      default: w_dx = '0;
    endcase
    w_row = $signed({1'b0, r_y}) + $signed({{YW{1'b0}}, w_dy})
          + $signed({{(YW-1){1'b0}}, w_r});
    w_col = $signed({1'b0, r_x}) + w_dx
          + $signed({{(XW-1){1'b0}}, w_c});
    w_illegal = (r_blk == 4'hF);
    // Rows never go negative (dy >= 0), so only the bottom edge is checked.
    w_oob = w_col[XW] || (int'(w_col) >= COLS) || (int'(w_row) >= ROWS);
  end

  // Next state and read strobe
  always_comb begin
    w_state_next = r_state;
    w_block      = 1'b0;
    w_rdEn       = 1'b0;
    case (r_state)
      S_IDLE: if (bus.Start) w_state_next = S_CELL;
      S_CELL: begin
        if (w_illegal || w_oob) begin
          w_block      = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_rdEn       = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.rdData != '0) begin
          w_block      = 1'b1;
          w_state_next = S_DONE;
        end else if (r_idx == 2'd3) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_CELL;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.rdEn    = w_rdEn;
  assign bus.rdRow   = w_rdEn ? w_row[YW-1:0] : '0;
  assign bus.rdCol   = w_rdEn ? w_col[XW-1:0] : '0;
  assign bus.Busy    = (r_state != S_IDLE);
  assign bus.Done    = (r_state == S_DONE);
  assign bus.canMove = r_canMove;

  // Control state; canMove is loaded on entry to DONE so it is valid with Done.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_idx     <= 2'd0;
      r_canMove <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && bus.Start)
        r_idx <= 2'd0;
      else if (r_state == S_WAIT && w_state_next == S_CELL)
        r_idx <= r_idx + 2'd1;
      if (w_state_next == S_DONE)
        r_canMove <= ~w_block;
    end
  end

  // Request snapshot; inputs are free to change once the check is underway.
  always_ff @(posedge Clock) begin
    if (r_state == S_IDLE && bus.Start) begin
      r_dir <= bus.Direction;
      r_blk <= bus.currentBlock;
      r_x   <= bus.XPOS;
      r_y   <= bus.YPOS;
    end
  end
endmodule

// File: tb/tb_move_checker.sv
module tb_move_checker;
  localparam int ROWS = 20;
  localparam int COLS = 16;
  localparam int CW   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [CW-1:0] board [0:ROWS-1][0:COLS-1];
  logic [15:0]   rdq [$];

  move_checker_if #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) bus ();
  move_checker #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Board RAM model: registered read, data valid the cycle after rdEn.
  always @(posedge clk) begin
    if (bus.rdEn) begin
      rdq.push_back({8'(bus.rdRow), 8'(bus.rdCol)});
      if (int'(bus.rdRow) < ROWS) bus.rdData <= board[bus.rdRow][bus.rdCol];
      else                        bus.rdData <= '1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request; measures the Done edge relative to the Start edge.
  task automatic run(input string tag, input logic [1:0] dir, input logic [3:0] blk,
                     input logic [3:0] x, input logic [4:0] y,
                     input int exp_edge, input logic exp_can, input int exp_nrd);
    int  k;
    logic can;
    rdq.delete();
    @(negedge clk);
    bus.Direction = dir; bus.currentBlock = blk; bus.XPOS = x; bus.YPOS = y;
    bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    chk({tag, " busy0"}, bus.Busy, 1'b1);
    k = 0; can = 1'bx;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(posedge clk); #1;
      if (bus.Done) begin k = i; can = bus.canMove; end
    end
    chk({tag, " done_edge"}, k, exp_edge);
    chk({tag, " canMove"}, can, exp_can);
    @(posedge clk); #1;
    chk({tag, " idle_after"}, {bus.Busy, bus.Done, bus.canMove}, {2'b00, exp_can});
    chk({tag, " nreads"}, rdq.size(), exp_nrd);
  endtask

  task automatic chk_rd(input string tag, input int i, input logic [15:0] exp);
    logic [15:0] v;
    v = (i < rdq.size()) ? rdq[i] : 16'hFFFF;
    chk(tag, v, exp);
  endtask

  initial begin
    int cnt, edge_at;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) board[r][c] = '0;
    bus.Start = 0; bus.Direction = 0; bus.currentBlock = 0; bus.XPOS = 0; bus.YPOS = 0;
    bus.rdData = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {bus.Busy, bus.Done, bus.canMove, bus.rdEn}, 4'b0000);
    chk("reset rdaddr", {bus.rdRow, bus.rdCol}, 9'd0);
    @(negedge clk); rst = 1'b0;

    // Empty board, I1 down from origin
    run("i1_down", 2'b00, 4'd0, 4'd0, 5'd0, 8, 1'b1, 4);
    chk_rd("i1_down rd0", 0, 16'h0400);
    chk_rd("i1_down rd1", 1, 16'h0401);
    chk_rd("i1_down rd2", 2, 16'h0402);
    chk_rd("i1_down rd3", 3, 16'h0403);

    // Bottom edge
    run("i1_floor", 2'b00, 4'd0, 4'd0, 5'd16, 1, 1'b0, 0);

    // Occupied cell on first check
    board[13][6] = 3'b101;
    run("t1_hit", 2'b00, 4'd9, 4'd5, 5'd10, 2, 1'b0, 1);
    chk_rd("t1_hit rd0", 0, 16'h0D06);

    // Left wall
    run("j1_left", 2'b01, 4'd5, 4'd0, 5'd5, 1, 1'b0, 0);

    // Right wall at cell 3
    run("i1_right", 2'b10, 4'd0, 4'd12, 5'd0, 7, 1'b0, 3);
    chk_rd("i1_right rd0", 0, 16'h030D);
    chk_rd("i1_right rd2", 2, 16'h030F);

    // Rotate T1 -> T2, blocked at cell 2
    board[7][5] = 3'd1;
    run("t1_rot", 2'b11, 4'd9, 4'd3, 5'd5, 6, 1'b0, 3);
    chk_rd("t1_rot rd0", 0, 16'h0604);
    chk_rd("t1_rot rd1", 1, 16'h0704);
    chk_rd("t1_rot rd2", 2, 16'h0705);

    // Rotate Z1 -> Z2, free
    run("z1_rot", 2'b11, 4'd13, 4'd0, 5'd0, 8, 1'b1, 4);
    chk_rd("z1_rot rd0", 0, 16'h0102);
    chk_rd("z1_rot rd3", 3, 16'h0301);

    // Rotate J4 -> J1 (wrap), blocked at last cell
    board[3][2] = 3'd2;
    run("j4_rot", 2'b11, 4'd8, 4'd0, 5'd0, 8, 1'b0, 4);
    chk_rd("j4_rot rd0", 0, 16'h0200);
    chk_rd("j4_rot rd3", 3, 16'h0302);

    // Illegal code
    run("illegal", 2'b00, 4'd15, 4'd4, 5'd4, 1, 1'b0, 0);

    // Start while Busy, inputs changed mid-check: ignored
    rdq.delete();
    @(negedge clk);
    bus.Direction = 2'b00; bus.currentBlock = 4'd2; bus.XPOS = 4'd4; bus.YPOS = 5'd0;
    bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0; bus.currentBlock = 4'd15; bus.Direction = 2'b01; bus.XPOS = 4'd0;
    @(posedge clk); #1;
    bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    cnt = 0; edge_at = 0;
    for (int i = 3; i <= 24; i++) begin
      @(posedge clk); #1;
      if (bus.Done) begin
        cnt++;
        if (edge_at == 0) begin
          edge_at = i;
          chk("busy_start canMove", bus.canMove, 1'b1);
        end
      end
    end
    chk("busy_start done_count", cnt, 1);
    chk("busy_start done_edge", edge_at, 8);
    chk("busy_start nreads", rdq.size(), 4);
    chk_rd("busy_start rd0", 0, 16'h0305);
    chk_rd("busy_start rd3", 3, 16'h0406);

    // Reset mid-check
    @(negedge clk);
    bus.Direction = 2'b00; bus.currentBlock = 4'd0; bus.XPOS = 4'd0; bus.YPOS = 5'd0;
    bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midreset outputs", {bus.Busy, bus.Done, bus.canMove, bus.rdEn}, 4'b0000);
    chk("midreset rdaddr", {bus.rdRow, bus.rdCol}, 9'd0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.Done || bus.Busy) cnt++;
    end
    chk("midreset no_activity", cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
